// File: rtl/program_loader_pkg.sv
// program_loader_pkg
//   Shared definitions for the instruction-memory program loader:
//   FSM state encoding, default halt encoding and byte-assembly sizing.
package program_loader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Same encoding the stop-pipe detector treats as halt.
    localparam logic [31:0] HALT_WORD_DEFAULT = 32'hFFFF_FFFF;

    localparam int BYTES_PER_WORD = 4;
    localparam int BCNT_W         = $clog2(BYTES_PER_WORD);

endpackage

// File: rtl/program_loader_byte_assembler.sv
// byte_assembler
//   Collects a big-endian byte stream into 32-bit words.
//   Ports:
//     clk, rst       clock, async active-high reset
//     i_clear        drop any partial word and restart at byte 0
//     i_valid        accept i_byte this cycle
//     i_byte         incoming byte (first byte of a word is its MSB)
//     o_word_ready   high in the cycle the 4th byte of a word is accepted
//     o_word         the completed word, valid while o_word_ready is high
import program_loader_pkg::*;

module byte_assembler (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_clear,
    input  logic        i_valid,
    input  logic [7:0]  i_byte,
    output logic        o_word_ready,
    output logic [31:0] o_word
);

    localparam logic [BCNT_W-1:0] LAST_BYTE = BCNT_W'(BYTES_PER_WORD - 1);

    logic [31:0]       shift_q, shift_d;
    logic [BCNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        if (i_clear) begin
            shift_d = '0;
            cnt_d   = '0;
        end else if (i_valid) begin
            shift_d = {shift_q[23:0], i_byte};
            cnt_d   = cnt_q + 1'b1;   // wraps to 0 after the 4th byte
        end
    end

    // The completed word is presented combinationally so the owner can
    // register it on the same edge the last byte is accepted.
    assign o_word_ready = i_valid && !i_clear && (cnt_q == LAST_BYTE);
    assign o_word       = {shift_q[23:0], i_byte};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/program_loader.sv
// program_loader
//   Debug-side writer for the fetch-stage instruction memory. Assembles
//   UART bytes into words and writes them at incrementing addresses until
//   the halt word is written or the memory is full.
//   Optional feature macro: PROGRAM_LOADER_CHECKSUM_EN -- after the halt
//   write, one extra byte must equal the XOR of all instruction bytes.
//   Ports:
//     clk, rst                 clock, async active-high reset
//     i_start                  begin a load (honoured in IDLE/DONE)
//     i_rx_data, i_rx_valid    received byte and its strobe
//     o_program_memory_write   one-cycle write enable
//     o_instruction_write      word to write
//     o_address_write          word address to write
//     o_busy, o_done, o_error  load status
import program_loader_pkg::*;

module program_loader #(
    parameter int          ADDR_W    = 8,
    parameter logic [31:0] HALT_WORD = HALT_WORD_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic [7:0]        i_rx_data,
    input  logic              i_rx_valid,
    output logic              o_program_memory_write,
    output logic [31:0]       o_instruction_write,
    output logic [ADDR_W-1:0] o_address_write,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_error
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              write_q, write_d;
    logic [31:0]       instr_q, instr_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    logic [7:0]        xor_q, xor_d;
`endif

    logic        start_ok;
    logic        asm_valid;
    logic        word_ready;
    logic [31:0] word;

    assign start_ok  = i_start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign asm_valid = i_rx_valid && (state_q == ST_LOAD);

    byte_assembler u_asm (
        .clk          (clk),
        .rst          (rst),
        .i_clear      (start_ok),
        .i_valid      (asm_valid),
        .i_byte       (i_rx_data),
        .o_word_ready (word_ready),
        .o_word       (word)
    );

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        write_d = 1'b0;
        instr_d = instr_q;
        waddr_d = waddr_q;
        busy_d  = busy_q;
        done_d  = done_q;
        error_d = error_q;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        xor_d   = xor_q;
`endif
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (i_start) begin
                    state_d = ST_LOAD;
                    addr_d  = '0;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    error_d = 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                    xor_d   = '0;
`endif
                end
            end
            ST_LOAD: begin
                // Termination is decided in the strobe cycle, so done/error
                // land one cycle after the write is presented.
                if (write_q) begin
                    if (instr_q == HALT_WORD) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                        state_d = ST_CHECK;
`else
                        state_d = ST_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
`endif
                    end else if (waddr_q == LAST_ADDR) begin
                        state_d = ST_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        error_d = 1'b1;
                    end
                end
                if (word_ready) begin
                    write_d = 1'b1;
                    instr_d = word;
                    waddr_d = addr_q;
                    // Saturate: the last address is never followed by a wrap.
                    if (addr_q != LAST_ADDR) addr_d = addr_q + 1'b1;
                end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                if (asm_valid) xor_d = xor_q ^ i_rx_data;
`endif
            end
            ST_CHECK: begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                if (i_rx_valid) begin
                    state_d = ST_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    error_d = (i_rx_data != xor_q);
                end
`else
                state_d = ST_IDLE;   // unreachable without the checksum
`endif
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            write_q <= 1'b0;
            instr_q <= '0;
            waddr_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            xor_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            write_q <= write_d;
            instr_q <= instr_d;
            waddr_q <= waddr_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            error_q <= error_d;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            xor_q   <= xor_d;
`endif
        end
    end

    assign o_program_memory_write = write_q;
    assign o_instruction_write    = instr_q;
    assign o_address_write        = waddr_q;
    assign o_busy                 = busy_q;
    assign o_done                 = done_q;
    assign o_error                = error_q;

endmodule

// File: doc/program_loader.md
# program_loader

Debug-side writer for the instruction memory in the fetch stage. It takes a byte stream from the UART receiver, assembles the bytes into 32-bit instruction words, and drives the program-memory write port with sequentially incrementing addresses. Loading ends when the halt instruction has been written. The debug unit holds the pipeline (`i_step` low) while this block is busy.

## Interface
Parameters:
- `ADDR_W`, default 8: program memory address width (256 words).
- `HALT_WORD`, default 32'hFFFF_FFFF: instruction encoding that terminates loading (same encoding the stop-pipe detector uses).

Ports:
- `clk`  input  1  single system clock.
- `rst`  input  1  reset, asynchronous, active-high.
- `i_start`  input  1  one-cycle request to begin a load.
- `i_rx_data`  input  8  received byte.
- `i_rx_valid`  input  1  one-cycle strobe; `i_rx_data` is valid this cycle.
- `o_program_memory_write`  output  1  one-cycle write enable to instruction memory.
- `o_instruction_write`  output  32  word to write.
- `o_address_write`  output  ADDR_W  word address to write.
- `o_busy`  output  1  high while a load is in progress.
- `o_done`  output  1  high when a load has finished; held until the next `i_start`.
- `o_error`  output  1  load ended abnormally; held until the next `i_start`.

## Operation
- States:
  - IDLE: reset state.
  - LOAD: receiving instruction words.
  - CHECK: exists only with the checksum feature.
  - DONE: load finished.
- IDLE:
  - `i_start` moves to LOAD, clears the byte counter, address and error, and sets busy.
  - `i_rx_valid` is ignored.
- LOAD: each `i_rx_valid` shifts the byte into the assembly register. The first byte of a word is its MSB (big-endian).
- When the 4th byte of a word is accepted:
  - On the next cycle, `o_program_memory_write`=1 for exactly one cycle.
  - `o_instruction_write` carries the assembled word.
  - `o_address_write` carries the current address.
  - The address then increments by 1.
  - The byte counter wraps to 0.
- If the written word equals `HALT_WORD`: go to DONE (or CHECK when the checksum feature is compiled in).
- If the word written at address 2^ADDR_W-1 is not `HALT_WORD`: set `o_error`=1, go to DONE, and perform no further writes. The address never wraps.
- DONE: `o_busy`=0 and `o_done`=1. `i_start` re-enters LOAD with the same clearing as from IDLE.
- `i_start` in LOAD or CHECK is ignored.
- `i_rx_valid` in DONE is ignored.
- `rst` asserted mid-load aborts immediately. A partial word is discarded and never written.

## Timing
- Reset values:
  - `o_program_memory_write`=0, `o_instruction_write`=0, `o_address_write`=0.
  - `o_busy`=0, `o_done`=0, `o_error`=0.
  - State IDLE.
- All outputs are registered.
- Latency: the write strobe appears 1 cycle after the strobe of the 4th byte.
- `o_address_write` and `o_instruction_write` are stable during the strobe cycle and hold their value until the next write.
- `o_busy` rises 1 cycle after `i_start`. `o_done` rises 1 cycle after the halt write strobe (no checksum).
- Back-to-back `i_rx_valid` on consecutive cycles must be accepted. A byte arriving in the same cycle as a write strobe is accepted normally.
- `i_start` and `i_rx_valid` in the same cycle in IDLE: start is taken and the byte is dropped.

## Configuration
- `PROGRAM_LOADER_CHECKSUM_EN` defined:
  - After the halt write, go to CHECK and wait for one more byte.
  - That byte must equal the XOR of all instruction bytes received in this load.
  - On a mismatch, `o_error`=1. On either outcome, go to DONE 1 cycle after the byte.
- Not defined:
  - CHECK state, XOR accumulator and related logic are absent.
  - Halt goes directly to DONE.

## Structure
- Shared package:
  - state encoding enum (IDLE/LOAD/CHECK/DONE);
  - default `HALT_WORD` constant;
  - bytes-per-word constant (4) and byte-counter width.
- Sub-module `byte_assembler`:
  - 32-bit shift register plus 2-bit byte counter;
  - a word-ready pulse and a clear input.
- The FSM, address counter and output registers stay in `program_loader`.

## Test plan
- Load 2 words then halt:
  - Send bytes 20 01 00 05, 00 00 00 00, FF FF FF FF.
  - Expect writes (0, 32'h2001_0005), (1, 0), (2, 32'hFFFF_FFFF).
  - Then `o_done`=1, `o_error`=0, `o_busy`=0.
- Overflow:
  - Send 256 non-halt words.
  - Expect 256 writes at addresses 0..255, then `o_error`=1 and `o_done`=1.
  - A 257th word produces no write.
- Reset mid-word:
  - Send 2 bytes, pulse `rst`, then `i_start` and a full halt word.
  - Expect a single write (0, 32'hFFFF_FFFF) and no stale bytes.
- Back-to-back bytes on consecutive cycles with `i_start` repeated during LOAD:
  - Expect a correct assembly.
  - The repeated `i_start` has no effect on address or data.
- Restart from DONE:
  - After a completed load, pulse `i_start` and send a halt word.
  - Expect the write at address 0, and `o_done` low until halt.
- With `PROGRAM_LOADER_CHECKSUM_EN`:
  - Load 20 01 00 05 + halt, then checksum 8'h24. Expect `o_error`=0.
  - Repeat with checksum 8'h00. Expect `o_error`=1.
